sssp_phase_ctrl: RTL and testbench

//  Sequences the N_PIPE sssp pipelines through a BFS-level SSSP sweep.
//  Per level, per vertex interval: loads 2^ADDR_W vertex lines (control=1),

---
 rtl/sssp_phase_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sssp_phase_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sssp_phase_ctrl.sv
// Phase sequencer for the SSSP pipeline array: per level and per vertex interval it
// loads the vertex lines, streams the edge lines, drains the pipelines, then decides on the next level.
module sssp_phase_ctrl #(
  parameter int ADDR_W = 8,
  parameter int N_PIPE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_ivl,
  input  logic [15:0]       max_level,
  input  logic [31:0]       vtx_base,
  output logic [15:0]       ivl_idx,
  input  logic [31:0]       ivl_edge_base,
  input  logic [31:0]       ivl_edge_lines,
  output logic              rd_req_valid,
  output logic [31:0]       rd_req_addr,
  input  logic              rd_req_ready,
  input  logic              rd_rsp_valid,
  input  logic [511:0]      rd_rsp_data,
  output logic              rd_rsp_ready,
  input  logic              upd_ready,
  output logic [511:0]      word_in,
  output logic              word_in_valid,
  output logic [31:0]       w_addr,
  output logic [1:0]        control,
  output logic              last_input,
  output logic [15:0]       current_level,
  input  logic [N_PIPE-1:0] pipe_last,
  input  logic [N_PIPE-1:0] pipe_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       levels_run
);

  typedef enum logic [2:0] {
    S_IDLE, S_LSTART, S_LOOKUP, S_VLOAD, S_EDGE, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  localparam logic [31:0] VLINES = 32'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       level_q, level_d;
  logic [15:0]       ivl_q, ivl_d;
  logic [15:0]       cur_lvl_q, cur_lvl_d;
  logic              upd_any_q, upd_any_d;
  logic [N_PIPE-1:0] last_seen_q, last_seen_d;
  logic [31:0]       req_cnt_q, req_cnt_d;
  logic [31:0]       rsp_cnt_q, rsp_cnt_d;
  logic [31:0]       ebase_q, ebase_d;
  logic [31:0]       elines_q, elines_d;
  logic [511:0]      word_q, word_d;
  logic              wvld_q, wvld_d;
  logic [1:0]        ctl_q, ctl_d;
  logic              last_q, last_d;
  logic [31:0]       waddr_q, waddr_d;

  logic        in_xfer;
  logic [31:0] ivl_off;
  logic [31:0] vbase;
  logic [31:0] phase_lines;
  logic [31:0] phase_base;
  logic        req_fire;
  logic        rsp_fire;
  logic        rsp_final;
  logic        upd_now;

  // Interval offset is formed in 32 bits so the vertex address wraps modulo 2^32.
  assign ivl_off     = {16'h0, ivl_q} << ADDR_W;
  assign vbase       = vtx_base + ivl_off;
  assign in_xfer     = (state_q == S_VLOAD) || (state_q == S_EDGE);
  assign phase_lines = (state_q == S_VLOAD) ? VLINES : elines_q;
  assign phase_base  = (state_q == S_VLOAD) ? vbase : ebase_q;

  assign rd_req_valid = in_xfer && (req_cnt_q < phase_lines);
  assign rd_req_addr  = in_xfer ? (phase_base + req_cnt_q) : 32'h0;
  assign rd_rsp_ready = in_xfer && upd_ready;
  assign req_fire     = rd_req_valid && rd_req_ready;
  assign rsp_fire     = rd_rsp_valid && rd_rsp_ready;
  assign rsp_final    = rsp_fire && (rsp_cnt_q == phase_lines - 32'd1);
  assign upd_now      = |pipe_valid;

  assign ivl_idx       = ivl_q;
  assign word_in       = word_q;
  assign word_in_valid = wvld_q;
  assign w_addr        = waddr_q;
  assign control       = ctl_q;
  assign last_input    = last_q;
  assign current_level = cur_lvl_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign levels_run    = (state_q == S_DONE) ? (level_q + 16'd1) : 16'h0;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    ivl_d       = ivl_q;
    cur_lvl_d   = cur_lvl_q;
    upd_any_d   = upd_any_q;
    last_seen_d = last_seen_q;
    req_cnt_d   = req_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    ebase_d     = ebase_q;
    elines_d    = elines_q;

    if (state_q != S_IDLE) upd_any_d = upd_any_q | upd_now;
    if (req_fire) req_cnt_d = req_cnt_q + 32'd1;
    if (rsp_fire) rsp_cnt_d = rsp_cnt_q + 32'd1;

    // Forward path: the line, its phase tag and addressing leave one cycle after the handshake.
    wvld_d  = rsp_fire;
    word_d  = rsp_fire ? rd_rsp_data : word_q;
    waddr_d = (rsp_fire && state_q == S_VLOAD) ? (vbase + rsp_cnt_q) : 32'h0;
    last_d  = rsp_final && (state_q == S_EDGE);
    case (state_q)
      S_VLOAD:         ctl_d = 2'd1;
      S_EDGE, S_DRAIN: ctl_d = 2'd2;
      default:         ctl_d = 2'd0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          level_d = 16'h0;
          ivl_d   = 16'h0;
          state_d = S_LSTART;
        end
      end
      S_LSTART: begin
        cur_lvl_d   = level_q;
        upd_any_d   = 1'b0;
        ivl_d       = 16'h0;
        last_seen_d = '0;
        state_d     = (num_ivl == 16'h0) ? S_DONE : S_LOOKUP;
      end
      S_LOOKUP: begin
        req_cnt_d = 32'h0;
        rsp_cnt_d = 32'h0;
        state_d   = S_VLOAD;
      end
      S_VLOAD: begin
        // The edge table entry has been stable for the whole load, so latch it here.
        if (rsp_final) begin
          ebase_d     = ivl_edge_base;
          elines_d    = ivl_edge_lines;
          req_cnt_d   = 32'h0;
          rsp_cnt_d   = 32'h0;
          last_seen_d = '0;
          state_d     = (ivl_edge_lines == 32'h0) ? S_NEXT : S_EDGE;
        end
      end
      S_EDGE: begin
        if (rsp_final) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        last_seen_d = last_seen_q | pipe_last;
        if (&(last_seen_q | pipe_last)) begin
          last_seen_d = '0;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if ((17'(ivl_q) + 17'd1) < 17'(num_ivl)) begin
          ivl_d   = ivl_q + 16'd1;
          state_d = S_LOOKUP;
        end else if (!(upd_any_q || upd_now) || (level_q == max_level)) begin
          state_d = S_DONE;
        end else begin
          level_d = level_q + 16'd1;
          state_d = S_LSTART;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      level_q     <= 16'h0;
      ivl_q       <= 16'h0;
      cur_lvl_q   <= 16'h0;
      upd_any_q   <= 1'b0;
      last_seen_q <= '0;
      req_cnt_q   <= 32'h0;
      rsp_cnt_q   <= 32'h0;
      ebase_q     <= 32'h0;
      elines_q    <= 32'h0;
      word_q      <= '0;
      wvld_q      <= 1'b0;
      ctl_q       <= 2'd0;
      last_q      <= 1'b0;
      waddr_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      ivl_q       <= ivl_d;
      cur_lvl_q   <= cur_lvl_d;
      upd_any_q   <= upd_any_d;
      last_seen_q <= last_seen_d;
      req_cnt_q   <= req_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      ebase_q     <= ebase_d;
      elines_q    <= elines_d;
      word_q      <= word_d;
      wvld_q      <= wvld_d;
      ctl_q       <= ctl_d;
      last_q      <= last_d;
      waddr_q     <= waddr_d;
    end
  end

endmodule

// File: tb/tb_sssp_phase_ctrl.sv
// Directed bench for sssp_phase_ctrl: memory responder, edge-table model, pipeline
// last/valid model and an in-order scoreboard of every forwarded line.
module tb_sssp_phase_ctrl;
  localparam int ADDR_W = 8;
  localparam int N_PIPE = 4;
  localparam int VL     = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [15:0]       num_ivl, max_level;
  logic [31:0]       vtx_base;
  logic [15:0]       ivl_idx;
  logic [31:0]       ivl_edge_base, ivl_edge_lines;
  logic              rd_req_valid;
  logic [31:0]       rd_req_addr;
  logic              rd_req_ready;
  logic              rd_rsp_valid;
  logic [511:0]      rd_rsp_data;
  logic              rd_rsp_ready;
  logic              upd_ready;
  logic [511:0]      word_in;
  logic              word_in_valid;
  logic [31:0]       w_addr;
  logic [1:0]        control;
  logic              last_input;
  logic [15:0]       current_level;
  logic [N_PIPE-1:0] pipe_last, pipe_valid;
  logic              busy, done;
  logic [15:0]       levels_run;

  always #5 clk = ~clk;

  sssp_phase_ctrl #(.ADDR_W(ADDR_W), .N_PIPE(N_PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ivl(num_ivl), .max_level(max_level),
    .vtx_base(vtx_base), .ivl_idx(ivl_idx), .ivl_edge_base(ivl_edge_base),
    .ivl_edge_lines(ivl_edge_lines), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_ready(rd_rsp_ready), .upd_ready(upd_ready), .word_in(word_in),
    .word_in_valid(word_in_valid), .w_addr(w_addr), .control(control),
    .last_input(last_input), .current_level(current_level), .pipe_last(pipe_last),
    .pipe_valid(pipe_valid), .busy(busy), .done(done), .levels_run(levels_run)
  );

  typedef struct {
    logic [1:0]  ctl;
    logic [31:0] waddr;
    logic        last;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] tbl_base[4];
  logic [31:0] tbl_lines[4];
  int          checks = 0, errors = 0;
  int          sb_err = 0, done_cnt = 0, req_cnt_tb = 0;
  int          pv_once_n = 0, pv_drain_n = 0;
  bit          rand_mode = 0, pv_every = 0;
  logic [15:0] lr_seen = 16'h0, cl_at_done = 16'h0;

  function automatic logic [511:0] mk(input logic [31:0] a);
    return {16{a ^ 32'hA5A5_0000}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Memory, edge table and pipeline responder: sample at posedge, drive 1 time unit later.
  initial begin : responder
    logic [15:0] idx;
    logic [3:0]  sh;
    logic        pv;
    int          once_used, drain_used;
    once_used = 0; drain_used = 0; sh = '0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; upd_ready = 1'b0;
    pipe_last = '0; pipe_valid = '0; ivl_edge_base = '0; ivl_edge_lines = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mem_q.delete();
        sh = '0;
      end else begin
        if (rd_rsp_valid && rd_rsp_ready) void'(mem_q.pop_front());
        if (rd_req_valid && rd_req_ready) begin
          mem_q.push_back(rd_req_addr);
          req_cnt_tb++;
        end
        sh = {sh[2:0], last_input};
      end
      idx = ivl_idx;
      #1;
      rd_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      upd_ready    = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_rsp_valid = (mem_q.size() > 0) && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      rd_rsp_data  = (mem_q.size() > 0) ? mk(mem_q[0]) : '0;
      pipe_last    = {N_PIPE{sh[3]}};
      pv = 1'b0;
      if (pv_every && sh[0]) pv = 1'b1;
      if (pv_once_n > once_used) begin pv = 1'b1; once_used++; end
      if (pv_drain_n > drain_used && sh[1]) begin pv = 1'b1; drain_used++; end
      pipe_valid     = pv ? 4'b0100 : 4'b0000;
      ivl_edge_base  = tbl_base[idx[1:0]];
      ivl_edge_lines = tbl_lines[idx[1:0]];
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (word_in_valid) begin
        if (exp_q.size() == 0) sb_err++;
        else begin
          e = exp_q.pop_front();
          if (control !== e.ctl || w_addr !== e.waddr || last_input !== e.last ||
              word_in !== mk(e.addr)) sb_err++;
        end
      end
      if (done) begin
        done_cnt++;
        lr_seen    = levels_run;
        cl_at_done = current_level;
      end
    end
  end

  task automatic build_exp(input int levels, input int nivl, input logic [31:0] vb);
    for (int l = 0; l < levels; l++)
      for (int i = 0; i < nivl; i++) begin
        for (int k = 0; k < VL; k++) begin
          logic [31:0] a;
          a = vb + 32'(i * VL) + 32'(k);
          exp_q.push_back('{ctl: 2'd1, waddr: a, last: 1'b0, addr: a});
        end
        for (int j = 0; j < int'(tbl_lines[i]); j++)
          exp_q.push_back('{ctl: 2'd2, waddr: 32'h0, last: (j == int'(tbl_lines[i]) - 1),
                            addr: tbl_base[i] + 32'(j)});
      end
  endtask

  task automatic start_run(input logic [15:0] nivl, input logic [15:0] mlvl, input logic [31:0] vb);
    num_ivl = nivl; max_level = mlvl; vtx_base = vb;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int levels, input int sb0, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, 64'(done_cnt != d0), 64'd1);
    chk({tag, "_levels_run"}, 64'(lr_seen), 64'(levels));
    chk({tag, "_sb_err"}, 64'(sb_err - sb0), 64'd0);
    chk({tag, "_lines_left"}, 64'(exp_q.size()), 64'd0);
    repeat (8) @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_idle"}, 64'({busy, levels_run}), 64'd0);
    exp_q.delete();
  endtask

  initial begin : stim
    int sb0, d0, r0, t;
    rst_n = 1'b0; start = 1'b0; num_ivl = '0; max_level = '0; vtx_base = '0;
    for (int i = 0; i < 4; i++) begin tbl_base[i] = '0; tbl_lines[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({rd_req_valid, rd_rsp_ready, word_in_valid, control, last_input,
                        busy, done, |word_in}), 64'd0);
    chk("rst_lvl", 64'({current_level, levels_run, ivl_idx}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One interval, 3 edge lines, one update in level 0 only.
    tbl_base[0] = 32'h0000_1000; tbl_lines[0] = 32'd3;
    build_exp(2, 1, 32'h200);
    sb0 = sb_err; d0 = done_cnt;
    start_run(16'd1, 16'd5, 32'h200);
    pv_once_n++;
    finish_run("one_ivl", 2, sb0, d0);

    // Two intervals, second has no edges.
    tbl_base[0] = 32'h0000_2000; tbl_lines[0] = 32'd2;
    tbl_base[1] = 32'h0000_3000; tbl_lines[1] = 32'd0;
    build_exp(1, 2, 32'h0001_0000);
    sb0 = sb_err; d0 = done_cnt;
    start_run(16'd2, 16'd5, 32'h0001_0000);
    finish_run("zero_edges", 1, sb0, d0);

    // Same with random backpressure and a start pulse while busy.
    rand_mode = 1;
    build_exp(1, 2, 32'h0001_0000);
    sb0 = sb_err; d0 = done_cnt;
    start_run(16'd2, 16'd5, 32'h0001_0000);
    repeat (60) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    finish_run("random_rdy", 1, sb0, d0);
    rand_mode = 0;

    // Updates every level, capped by max_level.
    pv_every = 1;
    tbl_base[0] = 32'h0000_4000; tbl_lines[0] = 32'd1;
    build_exp(4, 1, 32'h0000_8000);
    sb0 = sb_err; d0 = done_cnt;
    start_run(16'd1, 16'd3, 32'h0000_8000);
    finish_run("max_level", 4, sb0, d0);
    chk("max_level_cur", 64'(cl_at_done), 64'd3);
    pv_every = 0;

    // Update only during DRAIN; vertex addresses wrap at 2^32.
    tbl_base[0] = 32'h0000_5000; tbl_lines[0] = 32'd2;
    build_exp(2, 1, 32'hFFFF_FF80);
    sb0 = sb_err; d0 = done_cnt;
    pv_drain_n++;
    start_run(16'd1, 16'd7, 32'hFFFF_FF80);
    finish_run("drain_upd", 2, sb0, d0);

    // Reset in the middle of the edge phase.
    tbl_base[0] = 32'h0000_1000; tbl_lines[0] = 32'd3;
    build_exp(1, 1, 32'h200);
    d0 = done_cnt;
    start_run(16'd1, 16'd5, 32'h200);
    t = 0;
    while (!(word_in_valid && control == 2'd2) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("mid_edge_reached", 64'(t < 2000), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", 64'({rd_req_valid, rd_rsp_ready, word_in_valid, control, last_input,
                           busy, done, |word_in}), 64'd0);
    chk("midrst_addr", {rd_req_addr, w_addr}, 64'd0);
    chk("midrst_lvl", 64'({current_level, levels_run, ivl_idx}), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    build_exp(1, 1, 32'h200);
    sb0 = sb_err; d0 = done_cnt;
    start_run(16'd1, 16'd5, 32'h200);
    finish_run("after_rst", 1, sb0, d0);

    // Zero intervals: done two cycles after start, no memory traffic.
    r0 = req_cnt_tb; d0 = done_cnt;
    num_ivl = 16'd0; max_level = 16'd5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("zero_ivl_c1", 64'(done), 64'd0);
    @(negedge clk);
    chk("zero_ivl_c2", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("zero_ivl_reqs", 64'(req_cnt_tb - r0), 64'd0);
    chk("zero_ivl_once", 64'(done_cnt - d0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
